// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_controller_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DATA_MEM_BASE = 1024;
   localparam int SRAM_AW       = 17;
   localparam int SRAM_DW       = 32;

   // Byte address to SRAM word address; underflow wraps, low two bits dropped.
   function automatic logic [SRAM_AW-1:0] word_addr(input logic [31:0] addr,
                                                    input logic [31:0] base);
      logic [31:0] off;
      off = addr - base;
      return off[SRAM_AW+1:2];
   endfunction

endpackage

// File: rtl/sram_controller.sv
// MEM-stage to external SRAM bridge: stretches a one-cycle load/store into a
// fixed-length SRAM access and stalls the pipeline through ready.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int BASE_ADDR     = DATA_MEM_BASE,
   parameter int ACCESS_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic               SRAM_WE_N,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ
);

   localparam int CW = $clog2(ACCESS_CYCLES + 1);

   state_e             state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   logic               op_wr_q, op_wr_d;
   logic [SRAM_AW-1:0] addr_q, addr_d;
   logic [SRAM_DW-1:0] wdata_q, wdata_d;
   logic [SRAM_DW-1:0] rdata_q, rdata_d;
   logic               we_n_q, we_n_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         count_q <= '0;
         op_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         op_wr_q <= op_wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         we_n_q  <= we_n_d;
      end
   end

   // WE_N is computed one cycle ahead so the pin comes straight from a flop.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      op_wr_d = op_wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      we_n_d  = 1'b1;
      ready   = 1'b0;
      case (state_q)
         IDLE: begin
            ready = ~(wr_en | rd_en);
            if (wr_en | rd_en) begin
               state_d = BUSY;
               op_wr_d = wr_en;
               addr_d  = word_addr(address, 32'(BASE_ADDR));
               wdata_d = write_data;
               count_d = '0;
               we_n_d  = ~wr_en;
            end
         end
         BUSY: begin
            count_d = count_q + 1'b1;
            we_n_d  = ~op_wr_q;
            if (count_q == CW'(ACCESS_CYCLES - 1)) begin
               state_d = DONE;
               we_n_d  = 1'b1;
               if (!op_wr_q) rdata_d = SRAM_DQ;
            end
         end
         DONE: begin
            // The request still held here belongs to the finishing instruction.
            ready   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign SRAM_DQ   = we_n_q ? {SRAM_DW{1'bz}} : wdata_q;
   assign SRAM_WE_N = we_n_q;
   assign SRAM_ADDR = addr_q;
   assign read_data = rdata_q;

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sits between the MEM stage of the ARM pipeline and the external 32-bit SRAM (17-bit word address, active-low write enable, shared bidirectional data bus, 30 ns read access).
- Converts single-cycle load/store requests into multi-cycle SRAM accesses.
- Drives the SRAM pins and returns read data.
- Deasserts ready to freeze the pipeline until the access completes.

Parameters:
- BASE_ADDR, 1024: byte address where data memory starts; subtracted before word conversion.
- ACCESS_CYCLES, 4: cycles the SRAM pins are held per access. Must be >= 1 and >= ceil(30 ns / Tclk) + 1.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous active-low reset.
- wr_en  in  1  store request from MEM stage; level, held until ready.
- rd_en  in  1  load request from MEM stage; level, held until ready.
- address  in  32  byte address from ALU result.
- write_data  in  32  store data (Rm value).
- read_data  out  32  load result; holds last read word.
- ready  out  1  1 = no access pending or access finishing this cycle; 0 = freeze pipeline.
- SRAM_WE_N  out  1  SRAM write enable, active low.
- SRAM_ADDR  out  17  SRAM word address.
- SRAM_DQ  inout  32  SRAM data bus.

Behaviour:
- Reset (rst=0, async): state IDLE, count=0, SRAM_WE_N=1, SRAM_ADDR=0, latched op/data=0, read_data=0, SRAM_DQ released (Z).
- Address map: SRAM_ADDR = ((address - BASE_ADDR) >> 2) truncated to 17 bits. No range check; underflow wraps (1020 -> 0x1FFFF). Low two address bits ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - ready = ~(wr_en | rd_en), combinational.
  - On a request at posedge: latch op (write if wr_en, else read), SRAM_ADDR and write_data; count=0; go to BUSY.
  - wr_en & rd_en together: write wins.
- BUSY:
  - ready = 0.
  - Write: SRAM_WE_N=0 and SRAM_DQ driven with latched data for all ACCESS_CYCLES cycles. Repeated SRAM writes of the same word are harmless.
  - Read: SRAM_WE_N=1, SRAM_DQ = Z.
  - count increments each cycle. At the posedge where count == ACCESS_CYCLES-1: a read captures SRAM_DQ into read_data; go to DONE.
- DONE:
  - ready = 1 for exactly one cycle.
  - SRAM_WE_N=1, SRAM_DQ = Z.
  - Next state IDLE unconditionally. The request still asserted in DONE is the finishing instruction and must not retrigger.
- Latency: request seen in IDLE at cycle 0 -> ready=1 in cycle ACCESS_CYCLES+1. The stage occupies ACCESS_CYCLES+2 cycles. A back-to-back request starts from IDLE the cycle after DONE.
- SRAM_DQ is driven only when SRAM_WE_N=0, so the controller never drives while the SRAM drives.
- SRAM_WE_N, SRAM_ADDR and read_data are registered outputs (no glitches). ready is the only combinational output.
- Request inputs are sampled only in IDLE. Changes during BUSY/DONE are ignored.
- Reset mid-access: immediate return to IDLE, WE_N=1, bus released. A partially written word is acceptable; read_data is cleared to 0.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - DATA_MEM_BASE=1024;
  - SRAM_AW=17 and SRAM_DW=32.
- Counter width is $clog2(ACCESS_CYCLES+1).
- No sub-module: FSM, counter and tri-state driver stay in one module, under 200 lines.

Test Plan:
All scenarios use ACCESS_CYCLES=4, BASE_ADDR=1024, 20 ns clock, and the 30 ns-delay SRAM model on the bus.
1. Assert rst=0 mid-cycle, requests low -> immediately SRAM_WE_N=1, SRAM_DQ=Z, read_data=0, ready=1.
2. wr_en=1, address=1032, write_data=0xDEADBEEF -> SRAM_ADDR=2; SRAM_WE_N=0 for exactly 4 cycles; ready=0 for 5 cycles then 1 for one cycle; SRAM word 2 = 0xDEADBEEF.
3. rd_en=1, address=1032 after step 2 -> SRAM_WE_N stays 1; read_data=0xDEADBEEF when ready rises; ready high exactly one cycle.
4. Store to 1036 (0x12345678) held, then load from 1036 presented the cycle after DONE -> second access starts immediately; read_data=0x12345678. Bench asserts the controller never drives SRAM_DQ while SRAM_WE_N=1 (no X on the bus).
5. wr_en=1 and rd_en=1 together, address=1024+4*131071, data=0xA5A5A5A5 -> write performed at SRAM_ADDR=0x1FFFF; read_data unchanged. Then address=1020 read -> SRAM_ADDR=0x1FFFF, returns 0xA5A5A5A5.
6. Start write of 0xFFFFFFFF to 1040, pull rst=0 at BUSY count=1 -> asynchronously SRAM_WE_N=1, bus Z, state IDLE. After release with requests low, ready=1 and no further SRAM activity.
